// File: rtl/tia_line_doubler.sv
// TIA line doubler: captures each visible TIA scanline into one half of a
// ping-pong line buffer while the other half is replayed twice at 2x line
// rate. Output is a progressive 160x384 colour-index stream with sync/DE.
module tia_line_doubler #(
  parameter int H_TOTAL  = 228,
  parameter int VIS_X0   = 68,
  parameter int VIS_W    = 160,
  parameter int VIS_Y0   = 40,
  parameter int VIS_H    = 192,
  parameter int HS_START = 176,
  parameter int HS_LEN   = 16,
  parameter int VS_LINES = 3
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_pix_en,
  input  logic [6:0] i_cur_color,
  input  logic [7:0] i_x_pos,
  input  logic [8:0] i_scan_line,
  output logic [6:0] o_color_out,
  output logic       o_de,
  output logic       o_hsync_out,
  output logic       o_vsync_out,
  output logic [8:0] o_out_row,
  output logic [7:0] o_out_col
);

  localparam logic [7:0] LP_H_LAST   = 8'(H_TOTAL - 1);
  localparam logic [7:0] LP_VIS_X0   = 8'(VIS_X0);
  localparam logic [7:0] LP_VIS_X1   = 8'(VIS_X0 + VIS_W);
  localparam logic [7:0] LP_VIS_W    = 8'(VIS_W);
  localparam logic [7:0] LP_HS0      = 8'(HS_START);
  localparam logic [7:0] LP_HS1      = 8'(HS_START + HS_LEN);
  localparam logic [8:0] LP_VIS_Y0   = 9'(VIS_Y0);
  localparam logic [8:0] LP_VIS_Y1   = 9'(VIS_Y0 + VIS_H);
  localparam logic [8:0] LP_VS_LINES = 9'(VS_LINES);

  logic [6:0] r_bank [0:1][0:VIS_W-1];

  logic       r_wr_bank;
  logic       r_rd_bank;
  logic [1:0] r_valid;
  logic [7:0] r_out_x;
  logic [1:0] r_half;
  logic [8:0] r_row_base;
  // Attributes of the line currently being captured, committed at its end.
  logic [8:0] r_cur_line;
  logic       r_cur_vis;
  logic       r_cur_vs;

  logic       w_line_start;
  logic       w_wr_hit;
  logic [7:0] w_wr_idx;
  logic       w_line_vis;
  logic [8:0] w_line_off;
  logic [8:0] w_row_base;
  logic [7:0] w_rd_idx;
  logic [6:0] w_rd_data;
  logic       w_active;
  logic       w_hsync;

  assign w_line_start = i_pix_en && (i_x_pos == 8'd0);
  assign w_wr_hit     = i_pix_en && (i_x_pos >= LP_VIS_X0) && (i_x_pos < LP_VIS_X1);
  assign w_wr_idx     = i_x_pos - LP_VIS_X0;
  assign w_line_vis   = (i_scan_line >= LP_VIS_Y0) && (i_scan_line < LP_VIS_Y1);
  assign w_line_off   = r_cur_line - LP_VIS_Y0;
  assign w_row_base   = w_line_off << 1;

  // Out-of-range columns read entry 0; the value is masked by w_active anyway.
  assign w_rd_idx  = (r_out_x < LP_VIS_W) ? r_out_x : 8'd0;
  assign w_rd_data = r_bank[r_rd_bank][w_rd_idx];
  assign w_active  = (r_half < 2'd2) && r_valid[r_rd_bank] && (r_out_x < LP_VIS_W);
  assign w_hsync   = (r_half < 2'd2) && (r_out_x >= LP_HS0) && (r_out_x < LP_HS1);

  // Capture visible TIA pixels into the bank being written this line.
  always_ff @(posedge i_clk) begin
    if (w_wr_hit) begin
      r_bank[r_wr_bank][w_wr_idx] <= i_cur_color;
    end
  end

  // Bank swap at line start, otherwise free-running read position and half counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_bank  <= 1'b0;
      r_rd_bank  <= 1'b0;
      r_valid    <= 2'b00;
      r_out_x    <= 8'd0;
      r_half     <= 2'd2;
      r_row_base <= 9'd0;
      r_cur_line <= 9'd0;
      r_cur_vis  <= 1'b0;
      r_cur_vs   <= 1'b0;
    end else if (w_line_start) begin
      r_valid[r_wr_bank] <= r_cur_vis;
      r_rd_bank          <= r_wr_bank;
      r_wr_bank          <= ~r_wr_bank;
      r_out_x            <= 8'd0;
      r_half             <= 2'd0;
      r_row_base         <= w_row_base;
      r_cur_line         <= i_scan_line;
      r_cur_vis          <= w_line_vis;
      r_cur_vs           <= (i_scan_line < LP_VS_LINES);
    end else if (r_out_x == LP_H_LAST) begin
      r_out_x <= 8'd0;
      r_half  <= (r_half == 2'd2) ? 2'd2 : r_half + 2'd1;
    end else begin
      r_out_x <= r_out_x + 8'd1;
    end
  end

  // Single output register stage; everything lags the read position by one clock.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_color_out <= 7'd0;
      o_de        <= 1'b0;
      o_hsync_out <= 1'b0;
      o_vsync_out <= 1'b0;
      o_out_row   <= 9'd0;
      o_out_col   <= 8'd0;
    end else begin
      o_color_out <= w_active ? w_rd_data : 7'd0;
      o_de        <= w_active;
      o_hsync_out <= w_hsync;
      o_out_row   <= w_active ? (r_row_base + {7'd0, r_half}) : 9'd0;
      o_out_col   <= r_out_x;
      if (w_line_start) begin
        o_vsync_out <= r_cur_vs;
      end
    end
  end

endmodule

// File: tb/tb_tia_line_doubler.sv
// Scoreboard bench for tia_line_doubler: each issued TIA line pushes the
// pixels it should produce on replay; a negedge monitor pops on DE.
module tb_tia_line_doubler;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_en;
  logic [6:0] cur_color;
  logic [7:0] x_pos;
  logic [8:0] scan_line;
  logic [6:0] o_color_out;
  logic       o_de;
  logic       o_hsync_out;
  logic       o_vsync_out;
  logic [8:0] o_out_row;
  logic [7:0] o_out_col;

  typedef struct packed {
    logic [8:0] row;
    logic [7:0] col;
    logic [6:0] color;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b1;
  int   errors = 0;
  int   checks = 0;

  tia_line_doubler dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_pix_en    (pix_en),
    .i_cur_color (cur_color),
    .i_x_pos     (x_pos),
    .i_scan_line (scan_line),
    .o_color_out (o_color_out),
    .o_de        (o_de),
    .o_hsync_out (o_hsync_out),
    .o_vsync_out (o_vsync_out),
    .o_out_row   (o_out_row),
    .o_out_col   (o_out_col)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pat(input int mode, input int x);
    case (mode)
      0:       return 7'(x);
      1:       return 7'(x + 13);
      2:       return 7'h55;
      default: return 7'h2A;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pop one expected pixel per DE cycle, and require dark outputs otherwise.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (o_de) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL de_unexpected: row=%0d col=%0d color=%0d with nothing expected",
                   o_out_row, o_out_col, o_color_out);
        end else begin
          mon_e = exp_q.pop_front();
          if (o_out_row != mon_e.row || o_out_col != mon_e.col || o_color_out != mon_e.color) begin
            errors++;
            $display("FAIL pixel: got row=%0d col=%0d color=%0d expected row=%0d col=%0d color=%0d",
                     o_out_row, o_out_col, o_color_out, mon_e.row, mon_e.col, mon_e.color);
          end
        end
      end else if (o_color_out != 7'd0 || o_out_row != 9'd0) begin
        errors++;
        $display("FAIL dark: got color=%0d row=%0d expected 0 0", o_color_out, o_out_row);
      end
    end
  end

  // Issue xPos 0..n-1 of one TIA line (one pixel every second clock).
  // exp_rows replayed rows are pushed; cols the line did not reach keep old_mode data.
  task automatic drive_line(input int sl, input int n, input int mode, input int old_mode,
                            input int exp_rows, input int exp_vs, input int exp_hs,
                            input string tag);
    int   hs_cnt = 0;
    int   hs_col = -1;
    int   x;
    exp_t e;
    for (int k = 0; k < 2 * n; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        pix_en    = 1'b1;
        x_pos     = 8'(k / 2);
        scan_line = 9'(sl);
        cur_color = pat(mode, k / 2);
      end else begin
        pix_en = 1'b0;
      end
      if (o_hsync_out) begin
        hs_cnt++;
        if (hs_col < 0) hs_col = int'(o_out_col);
      end
      if (exp_vs >= 0 && (k == 100 || k == 2 * n - 2))
        check($sformatf("vsync_%s_k%0d", tag, k), int'(o_vsync_out), exp_vs);
    end
    if (exp_hs >= 0) begin
      check({"hsync_len_", tag}, hs_cnt, exp_hs);
      check({"hsync_col_", tag}, hs_col, 176);
    end
    for (int h = 0; h < exp_rows; h++) begin
      for (int c = 0; c < 160; c++) begin
        x = 68 + c;
        e.row   = 9'(2 * (sl - 40) + h);
        e.col   = 8'(c);
        e.color = (x < n) ? pat(mode, x) : pat(old_mode, x);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({"color_", tag}, int'(o_color_out), 0);
    check({"de_", tag},    int'(o_de), 0);
    check({"hsync_", tag}, int'(o_hsync_out), 0);
    check({"vsync_", tag}, int'(o_vsync_out), 0);
    check({"row_", tag},   int'(o_out_row), 0);
    check({"col_", tag},   int'(o_out_col), 0);
  endtask

  initial begin
    int de_cnt;
    rst       = 1'b1;
    pix_en    = 1'b0;
    cur_color = 7'd0;
    x_pos     = 8'd0;
    scan_line = 9'd0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Vertical sync lines, then one invisible line.
    drive_line(0,  228, 3, 3, 0, 0, 32, "sl0");
    drive_line(1,  228, 3, 3, 0, 1, 32, "sl1");
    drive_line(2,  228, 3, 3, 0, 1, 32, "sl2");
    drive_line(3,  228, 3, 3, 0, 1, 32, "sl3");
    drive_line(10, 228, 3, 3, 0, 0, 32, "sl10");
    // Visible lines 50..53 -> rows 20..27.
    for (int s = 50; s < 54; s++)
      drive_line(s, 228, 0, 0, 2, 0, 32, $sformatf("sl%0d", s));
    // A full, B full (second replay row cut short by C), C truncated at xPos 100.
    drive_line(60, 228, 0, 0, 2, 0, 32, "A");
    drive_line(61, 228, 1, 1, 1, 0, 32, "B");
    drive_line(62, 100, 2, 0, 2, 0, 16, "C");
    drive_line(63, 228, 1, 1, 2, 0, 32, "D");
    drive_line(80, 228, 0, 0, 2, 0, 32, "G");
    // One invisible line start, then PixEn held low.
    drive_line(300, 1, 3, 3, 0, -1, -1, "stop");
    de_cnt = 0;
    repeat (1500) begin
      @(negedge clk);
      if (o_de) de_cnt++;
    end
    check("idle_de_count", de_cnt, 320);
    check("idle_queue_empty", exp_q.size(), 0);

    // Reset in the middle of an active output row.
    drive_line(90, 228, 1, 1, 0, 0, 32, "H");
    mon_en = 1'b0;
    drive_line(91, 40, 3, 3, 0, -1, -1, "I");
    @(negedge clk);
    check("de_before_reset", int'(o_de), 1);
    rst    = 1'b1;
    pix_en = 1'b0;
    @(negedge clk);
    check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mon_en = 1'b1;
    drive_line(100, 228, 1, 1, 2, 0, 32, "J");
    drive_line(101, 228, 0, 0, 0, 0, 32, "K");
    repeat (20) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
